// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID pipeline types: the decode-facing bus, the queue entry and the bubble instruction.
package if_id_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_entry_t;

    function automatic if_id_bus_t entry_to_bus(input if_id_entry_t e);
        if_id_bus_t b;
        b.pc          = e.pc;
        b.instruction = e.instr;
        return b;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// IF/ID queue signal bundle; master is the IF/ID pipeline side, slave is the queue.
interface if_id_queue_if;
    import if_id_queue_pkg::*;

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_stall;
    logic        fetch_stall;
    logic        id_valid;
    if_id_bus_t  if_id_bus_out;
    logic [31:0] stall_count;

    modport master (
        output if_valid, if_pc, if_instr, flush, id_stall,
        input  fetch_stall, id_valid, if_id_bus_out, stall_count
    );

    modport slave (
        input  if_valid, if_pc, if_instr, flush, id_stall,
        output fetch_stall, id_valid, if_id_bus_out, stall_count
    );

endinterface

// File: rtl/if_id_queue_sync_fifo.sv
// Synchronous FIFO with flush; push is refused when full, pop when empty, both when flushing.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 on its own.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_id_queue.sv
// IF-to-ID instruction queue: buffers fetched {pc, instr} pairs, presents a NOP bubble when empty,
// back-pressures fetch when full and counts fetch-stall cycles.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = if_id_queue_pkg::NOP_INSTR
) (
    input logic          clock,
    input logic          reset,
    if_id_queue_if.slave bus
);
    import if_id_queue_pkg::*;

    localparam int AW = $clog2(DEPTH);

    if_id_entry_t wr_entry;
    if_id_entry_t rd_entry;
    logic [AW:0]  count;

    assign wr_entry.pc    = bus.if_pc;
    assign wr_entry.instr = bus.if_instr;

    sync_fifo #(
        .WIDTH ($bits(if_id_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.if_valid),
        .pop   (!bus.id_stall),
        .flush (bus.flush),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count)
    );

    // All outputs derive from the registered count and storage, never from id_stall or flush.
    assign bus.fetch_stall = (count == (AW+1)'(DEPTH));
    assign bus.id_valid    = (count != '0);

    always_comb begin
        bus.if_id_bus_out.pc          = 32'h0;
        bus.if_id_bus_out.instruction = NOP_INSTR;
        if (bus.id_valid) bus.if_id_bus_out = entry_to_bus(rd_entry);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.stall_count <= '0;
        end else if (bus.fetch_stall && (bus.stall_count != 32'hFFFF_FFFF)) begin
            bus.stall_count <= bus.stall_count + 32'd1;
        end
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between IF and ID in the 5-stage RISC-V core. Each cycle it captures the fetched {PC, instruction} pair, buffers up to DEPTH entries so that an ID stall does not immediately stall fetch, and presents the oldest entry to decode on `if_id_bus_out`. On a taken branch or JALR redirect it flushes all entries, and it back-pressures IF through `fetch_stall` when full.

## Interface
Parameters:
- DEPTH, 2, number of queue entries; power of two, ≥ 2
- NOP_INSTR, 32'h0000_0013, instruction word presented when the queue is empty (ADDI x0,x0,0)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`
- if_valid  in  1  IF presents a fetched instruction this cycle
- if_pc  in  32  PC of the fetched instruction
- if_instr  in  32  instruction word from IMemory for `if_pc`
- flush  in  1  redirect: taken branch or JALR resolved this cycle
- id_stall  in  1  ID cannot accept an instruction this cycle
- fetch_stall  out  1  queue full; drives IF `stall`
- id_valid  out  1  `if_id_bus_out` holds a real instruction
- if_id_bus_out  out  if_id_bus_t  head entry; `pc` and `instruction` fields
- stall_count  out  32  saturating count of cycles with `fetch_stall`=1

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, plus write pointer, read pointer (log2(DEPTH) bits, wrapping) and count (log2(DEPTH)+1 bits).
- Enqueue condition: `if_valid && !fetch_stall && !flush`. The pair is written at the write pointer, and the write pointer advances modulo DEPTH.
- Dequeue condition: `id_valid && !id_stall && !flush`. The read pointer advances modulo DEPTH.
- Count update:
  - +1 on enqueue only
  - −1 on dequeue only
  - unchanged on simultaneous enqueue and dequeue
- `fetch_stall` = (count == DEPTH). This is registered state only. When full, no enqueue happens even if a dequeue occurs in the same cycle; IF retries next cycle.
- `id_valid` = (count != 0).
- `if_id_bus_out`:
  - when `id_valid`=1: the entry at the read pointer
  - otherwise: pc = 0, instruction = NOP_INSTR
- Flush has highest priority. It sets count = 0 and both pointers = 0, and the same-cycle `if_valid` is discarded. IF supplies the redirected PC on the following cycle.
- `stall_count` increments each cycle that `fetch_stall`=1 and saturates at 32'hFFFF_FFFF. Flush does not clear it.
- Reset (`reset`=0 at an edge) clears count, pointers and `stall_count`. Entry contents are don't-care. Reset overrides flush, enqueue and dequeue. A reset mid-stream discards all entries.

## Timing
- Reset values: `fetch_stall`=0, `id_valid`=0, `if_id_bus_out`={0, NOP_INSTR}, `stall_count`=0.
- Latency: a pair enqueued at edge N is visible on `if_id_bus_out` with `id_valid`=1 after edge N. There is no combinational bypass from `if_*` to outputs.
- Every output is a function of registered state only, with no path from `id_stall` or `flush`. ID therefore sees stable outputs for the whole cycle.
- After a flush at edge N, outputs show the bubble until the first post-flush enqueue becomes visible at edge N+1 at the earliest.
- Full/empty:
  - an enqueue that makes count = DEPTH asserts `fetch_stall` from the next cycle
  - one dequeue from full deasserts it from the next cycle
- Pointer wrap: pointer DEPTH−1 advances to 0. The count, not the pointer equality, distinguishes full from empty.

## Structure
- Add `if_id_entry_t` {pc, instr} and `NOP_INSTR` to the shared pipeline package alongside `if_id_bus_t`.
- One sub-module: `sync_fifo`, parameterised by width and DEPTH, providing push/pop/flush/count. `if_id_queue` wraps it and adds the bubble mux and stall counter.

## Test plan
- Reset then idle: drive `reset`=0 for 2 cycles, then release with `if_valid`=0. Required: `id_valid`=0, bus = {0, 32'h13}, `fetch_stall`=0, `stall_count`=0.
- Streaming: `if_valid`=1 with pc 0,4,8… and `id_stall`=0. Required: pc 0 appears one cycle after its enqueue, one entry per cycle follows, and `fetch_stall` stays 0.
- Fill with DEPTH=2: `id_stall`=1 while enqueuing pc 0x10 and 0x14. Required: `fetch_stall`=1 after the second edge, a third pc 0x18 is not stored, and `stall_count` increments each stalled cycle.
- Drain and wrap: from the fill scenario, release `id_stall`. Required: outputs show 0x10, then 0x14, then 0x18 (0x18 re-enqueued once `fetch_stall` drops), with correct order across the pointer wrap.
- Flush: with 2 entries queued, assert `flush` together with `if_valid` at pc 0x40. Required: next cycle `id_valid`=0 and 0x40 is not stored; pc 0x80 enqueued the following cycle appears one cycle later.
- Reset mid-operation: assert `reset`=0 with the queue full. Required: after that edge `id_valid`=0, `fetch_stall`=0 and `stall_count`=0.
